ring_tuning_controller: RTL and testbench
=========================================

RING_TUNING_CONTROLLER -- requirements
Module: ring_tuning_controller

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8: heater code width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 16: cycles ignored after each code change.
REQ-003 SHALL have parameter DWELL_SAMPLES, default 64: valid receiver samples measured per code.
REQ-004 SHALL have parameter CNT_WIDTH, default 10: score counter width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: single-cycle pulse that begins a heater sweep.
REQ-008 SHALL have port rx_bit, input, 1: receiver decision (current-integrating receiver output).
REQ-009 SHALL have port rx_valid, input, 1: rx_bit qualifier, one sample per high cycle.
REQ-010 SHALL have port heater, output, 1: PDM heater drive to the thermal tuner.
REQ-011 SHALL have port heater_code, output, BIT_WIDTH: current heater code.
REQ-012 SHALL have port busy, output, 1: high in SETTLE, MEASURE and NEXT.
REQ-013 SHALL have port locked, output, 1: high only in LOCKED.
REQ-014 SHALL have port best_score, output, CNT_WIDTH: highest score found in the current or last sweep.

Function
REQ-015 SHALL implement the states IDLE, SETTLE, MEASURE, NEXT and LOCKED.
REQ-016 IDLE: start -> heater_code=0, best_score=0, best_code=0, go to SETTLE.
REQ-017 SETTLE: count SETTLE_CYCLES clocks, ignore rx inputs, then go to MEASURE with sample and score counters cleared.
REQ-018 MEASURE: on each rx_valid, increment the sample count; if rx_bit=1, also increment the score.
REQ-019 The score SHALL saturate at 2^CNT_WIDTH-1.
REQ-020 MEASURE SHALL leave in the cycle after the DWELL_SAMPLES-th valid sample; cycles without rx_valid do not advance it.
REQ-021 NEXT (one cycle): if score > best_score (strict, so the lowest code wins a tie), set best_score=score and best_code=heater_code.
REQ-022 NEXT: if heater_code = 2^BIT_WIDTH-1, set heater_code=best_code (including any update from REQ-021) and go to LOCKED.
REQ-023 NEXT: otherwise increment heater_code and go to SETTLE; heater_code SHALL never wrap.
REQ-024 LOCKED: hold heater_code; start -> restart as in REQ-016.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 PDM: a (BIT_WIDTH+1)-bit accumulator SHALL add heater_code every cycle in all states; heater = the registered carry-out.
REQ-027 With code=0, heater SHALL stay 0; with code C, heater SHALL be high for exactly C of every 2^BIT_WIDTH cycles.
REQ-028 rx_valid in IDLE, SETTLE, NEXT or LOCKED SHALL not alter the score, except as allowed by REQ-034.

Reset
REQ-029 rst SHALL act at the next clock edge and override start.
REQ-030 During reset the block SHALL go to IDLE with heater_code=0, accumulator=0, heater=0, busy=0, locked=0, best_score=0, and all counters cleared.
REQ-031 Reset mid-sweep SHALL discard all partial results; outputs follow REQ-030 in the cycle after rst is sampled.

Configuration
REQ-032 The macro RING_TUNER_TRACK_EN SHALL enable lock monitoring.
REQ-033 With RING_TUNER_TRACK_EN defined: in LOCKED, score windows of DWELL_SAMPLES valid samples SHALL repeat continuously.
REQ-034 With RING_TUNER_TRACK_EN defined: if a window's score < best_score/2 (floor), locked SHALL drop and the block SHALL restart as in REQ-016 in the next cycle.
REQ-035 Without RING_TUNER_TRACK_EN: LOCKED SHALL hold until start or rst, and no monitor logic SHALL be present.

Verification
REQ-036 BIT_WIDTH=2, rx_bit=1 only at code 2, rx_valid=1 -> locked after the sweep, heater_code=2, best_score=64.
REQ-037 Equal scores at codes 1 and 3 -> heater_code=1 (tie goes to the lowest code).
REQ-038 rx_valid toggling every other cycle -> each MEASURE lasts 128 cycles and the result is the same as with continuous rx_valid.
REQ-039 heater_code=64, BIT_WIDTH=8, over 256 cycles -> exactly 64 heater-high cycles; code 0 -> 0 heater-high cycles.
REQ-040 rst asserted mid-MEASURE -> next cycle IDLE with all outputs 0; a start during the sweep is ignored.
REQ-041 With TRACK_EN, best_score=64 and then rx_bit=0 -> locked falls after one window, and the sweep restarts from code 0.

Source files
------------

// File: rtl/ring_tuning_controller.sv
// ---------------------------------------------------------------------------
// ring_tuning_controller
//
// Sweeps a ring-resonator heater code from 0 to 2^BIT_WIDTH-1. At each code
// it waits for the thermal tuner to settle, scores the receiver (counts
// rx_bit=1 over DWELL_SAMPLES valid samples), remembers the best code, and
// finally parks on the best code (lowest code wins a tie). The heater is
// driven by a first-order PDM modulator running continuously on the current
// code.
//
// Optional feature (macro RING_TUNER_TRACK_EN): while locked, keep scoring
// back-to-back windows; if a window's score falls below half of best_score
// the block drops lock and restarts the sweep from code 0.
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   one-cycle pulse, begins a sweep (ignored while busy)
//   rx_bit       in   receiver decision
//   rx_valid     in   rx_bit qualifier, one sample per high cycle
//   heater       out  PDM heater drive (registered carry-out)
//   heater_code  out  current heater code [BIT_WIDTH]
//   busy         out  high in SETTLE, MEASURE and NEXT
//   locked       out  high only in LOCKED
//   best_score   out  best score of the current or last sweep [CNT_WIDTH]
// ---------------------------------------------------------------------------
module ring_tuning_controller #(
    parameter int BIT_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_SAMPLES = 64,
    parameter int CNT_WIDTH     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rx_bit,
    input  logic                 rx_valid,
    output logic                 heater,
    output logic [BIT_WIDTH-1:0] heater_code,
    output logic                 busy,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] best_score
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int SMP_W = $clog2(DWELL_SAMPLES + 1);

    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [SET_W-1:0]     SET_ONE     = SET_W'(1);
    localparam logic [SMP_W-1:0]     SMP_LAST    = SMP_W'(DWELL_SAMPLES - 1);
    localparam logic [SMP_W-1:0]     SMP_ONE     = SMP_W'(1);
    localparam logic [BIT_WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [BIT_WIDTH-1:0] CODE_ONE    = BIT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] SCORE_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] SCORE_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_NEXT,
        ST_LOCKED
    } state_t;

    state_t               state_q;
    logic [BIT_WIDTH-1:0] heater_code_q;
    logic [BIT_WIDTH-1:0] best_code_q;
    logic [CNT_WIDTH-1:0] best_score_q;
    logic [CNT_WIDTH-1:0] score_q;
    logic [SET_W-1:0]     settle_cnt_q;
    logic [SMP_W-1:0]     sample_cnt_q;
    logic                 busy_q;
    logic                 locked_q;

    // PDM modulator state
    logic [BIT_WIDTH-1:0] acc_q;
    logic [BIT_WIDTH:0]   acc_d;
    logic                 heater_q;

    // Helpers shared by MEASURE and the lock monitor
    logic [CNT_WIDTH-1:0] score_d;
    logic                 window_done;
    logic                 better;
    logic                 track_fail;
    logic                 restart;

    always_comb begin
        score_d     = score_q;
        if (rx_bit && (score_q != SCORE_MAX)) begin
            score_d = score_q + SCORE_ONE;
        end
        window_done = rx_valid && (sample_cnt_q == SMP_LAST);
        better      = (score_q > best_score_q);
`ifdef RING_TUNER_TRACK_EN
        // score_d is the score including this cycle's final sample
        track_fail  = (state_q == ST_LOCKED) && window_done &&
                      (score_d < (best_score_q >> 1));
`else
        track_fail  = 1'b0;
`endif
        // start is only honoured in the non-busy states
        restart     = (((state_q == ST_IDLE) || (state_q == ST_LOCKED)) && start) ||
                      track_fail;
    end

    // Sweep FSM with registered busy/locked
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            heater_code_q <= '0;
            best_code_q   <= '0;
            best_score_q  <= '0;
            score_q       <= '0;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
            busy_q        <= 1'b0;
            locked_q      <= 1'b0;
        end else if (restart) begin
            state_q       <= ST_SETTLE;
            heater_code_q <= '0;
            best_code_q   <= '0;
            best_score_q  <= '0;
            score_q       <= '0;
            settle_cnt_q  <= '0;
            sample_cnt_q  <= '0;
            busy_q        <= 1'b1;
            locked_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q      <= ST_MEASURE;
                        settle_cnt_q <= '0;
                        sample_cnt_q <= '0;
                        score_q      <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SET_ONE;
                    end
                end

                ST_MEASURE: begin
                    if (rx_valid) begin
                        sample_cnt_q <= sample_cnt_q + SMP_ONE;
                        score_q      <= score_d;
                        if (window_done) begin
                            state_q <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    if (better) begin
                        best_score_q <= score_q;
                        best_code_q  <= heater_code_q;
                    end
                    if (heater_code_q == CODE_MAX) begin
                        // best_code_q is not yet updated this cycle, so
                        // pick the current code directly if it just won
                        heater_code_q <= better ? heater_code_q : best_code_q;
                        state_q       <= ST_LOCKED;
                        sample_cnt_q  <= '0;
                        score_q       <= '0;
                        busy_q        <= 1'b0;
                        locked_q      <= 1'b1;
                    end else begin
                        heater_code_q <= heater_code_q + CODE_ONE;
                        settle_cnt_q  <= '0;
                        state_q       <= ST_SETTLE;
                    end
                end

                ST_LOCKED: begin
`ifdef RING_TUNER_TRACK_EN
                    // Back-to-back monitor windows; a failing window is
                    // handled by the restart branch above
                    if (rx_valid) begin
                        if (window_done) begin
                            sample_cnt_q <= '0;
                            score_q      <= '0;
                        end else begin
                            sample_cnt_q <= sample_cnt_q + SMP_ONE;
                            score_q      <= score_d;
                        end
                    end
`endif
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // First-order PDM: carry-out of a (BIT_WIDTH+1)-bit sum gives exactly
    // heater_code high cycles in every 2^BIT_WIDTH window
    always_comb begin
        acc_d = {1'b0, acc_q} + {1'b0, heater_code_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            heater_q <= 1'b0;
        end else begin
            acc_q    <= acc_d[BIT_WIDTH-1:0];
            heater_q <= acc_d[BIT_WIDTH];
        end
    end

    assign heater      = heater_q;
    assign heater_code = heater_code_q;
    assign busy        = busy_q;
    assign locked      = locked_q;
    assign best_score  = best_score_q;

endmodule

// File: tb/tb_ring_tuning_controller.sv
// Directed bench for ring_tuning_controller: sweep/lock behaviour on a
// 2-bit instance and PDM duty on an 8-bit instance.
module tb_ring_tuning_controller;

    logic       clk;
    logic       rst;
    logic       start;
    logic       rx_valid;
    logic       rx_bit;
    logic [3:0] pattern;
    logic       heater;
    logic [1:0] heater_code;
    logic       busy;
    logic       locked;
    logic [9:0] best_score;

    logic       start8;
    logic       rx_valid8;
    logic       rx_bit8;
    logic       heater8;
    logic [7:0] heater_code8;
    logic       busy8;
    logic       locked8;
    logic [3:0] best_score8;

    int n_checks = 0;
    int n_fail   = 0;

    // Receiver response: rx_bit=1 at the heater codes flagged in pattern
    assign rx_bit = pattern[heater_code];

    ring_tuning_controller #(
        .BIT_WIDTH(2), .SETTLE_CYCLES(4), .DWELL_SAMPLES(64), .CNT_WIDTH(10)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rx_bit(rx_bit),
        .rx_valid(rx_valid), .heater(heater), .heater_code(heater_code),
        .busy(busy), .locked(locked), .best_score(best_score)
    );

    ring_tuning_controller #(
        .BIT_WIDTH(8), .SETTLE_CYCLES(2), .DWELL_SAMPLES(4), .CNT_WIDTH(4)
    ) dut8 (
        .clk(clk), .rst(rst), .start(start8), .rx_bit(rx_bit8),
        .rx_valid(rx_valid8), .heater(heater8), .heater_code(heater_code8),
        .busy(busy8), .locked(locked8), .best_score(best_score8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cyc;
        int h;

        rst       = 1'b1;
        start     = 1'b0;
        rx_valid  = 1'b0;
        pattern   = 4'b0000;
        start8    = 1'b0;
        rx_valid8 = 1'b0;
        rx_bit8   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_code",   32'(heater_code), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_best",   32'(best_score), 0);
        check("rst_heater", 32'(heater), 0);
        rst = 1'b0;
        @(negedge clk);

        // Sweep with score only at code 2; extra starts while busy must be ignored
        pattern  = 4'b0100;
        rx_valid = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("a_busy_after_start", 32'(busy), 1);
        while (!locked && cyc < 2000) begin
            start = (cyc == 1 || cyc == 150);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("a_sweep_cycles", 32'(cyc), 277);
        check("a_locked", 32'(locked), 1);
        check("a_busy",   32'(busy), 0);
        check("a_code",   32'(heater_code), 2);
        check("a_best",   32'(best_score), 64);
        h = 0;
        repeat (8) begin
            @(negedge clk);
            h += int'(heater);
        end
        check("a_pdm_code2_8cyc", 32'(h), 4);

        // Equal scores at codes 1 and 3 -> lowest code
        pattern = 4'b1010;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!locked && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("b_locked", 32'(locked), 1);
        check("b_code",   32'(heater_code), 1);
        check("b_best",   32'(best_score), 64);

        // rx_valid every other cycle; rx_bit ignored on invalid cycles
        pattern = 4'b0100;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!locked && cyc < 3000) begin
            rx_valid = cyc[0];
            @(negedge clk);
            cyc++;
        end
        rx_valid = 1'b1;
        check("c_cycles_in_range", 32'(cyc >= 529 && cyc <= 533), 1);
        check("c_code", 32'(heater_code), 2);
        check("c_best", 32'(best_score), 64);

        // Receiver goes dark while locked
        pattern = 4'b0000;
        cyc     = 0;
`ifdef RING_TUNER_TRACK_EN
        while (locked && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("t_drop_cycles", 32'(cyc), 64);
        check("t_code", 32'(heater_code), 0);
        check("t_busy", 32'(busy), 1);
        check("t_best", 32'(best_score), 0);
`else
        repeat (300) @(negedge clk);
        check("h_locked", 32'(locked), 1);
        check("h_code",   32'(heater_code), 2);
        check("h_best",   32'(best_score), 64);
`endif

        // Reset mid-MEASURE, with start asserted alongside
        pattern = 4'b0100;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("r_code",   32'(heater_code), 0);
        check("r_busy",   32'(busy), 0);
        check("r_locked", 32'(locked), 0);
        check("r_best",   32'(best_score), 0);
        check("r_heater", 32'(heater), 0);
        rst   = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("r_stays_idle", 32'(busy), 0);

        // PDM on the 8-bit instance: code 0 gives no heater pulses
        h = 0;
        repeat (256) begin
            @(negedge clk);
            h += int'(heater8);
        end
        check("p_code0_high", 32'(h), 0);

        // Sweep to code 64, then starve rx_valid so the code holds
        rx_valid8 = 1'b1;
        start8    = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        cyc    = 0;
        while (heater_code8 != 8'd64 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        rx_valid8 = 1'b0;
        check("p_reached_64", 32'(heater_code8), 64);
        repeat (4) @(negedge clk);
        h = 0;
        repeat (256) begin
            @(negedge clk);
            h += int'(heater8);
        end
        check("p_code64_high", 32'(h), 64);
        check("p_code_held", 32'(heater_code8), 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
